// File: rtl/obuf_drain_pkg.sv
// Shared types and default widths for the obuf drain reader (obuf_drain and obuf_drain_fifo).
package obuf_drain_pkg;

    localparam int DEFAULT_MEM_ADDR_WIDTH = 15;
    localparam int DEFAULT_MEM_DATA_WIDTH = 256;
    localparam int DEFAULT_LEN_WIDTH      = 16;
    localparam int DEFAULT_FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/obuf_drain_fifo.sv
// Small synchronous FIFO that absorbs obuf read data; exposes count and the head entry directly.
module obuf_drain_fifo
    import obuf_drain_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_MEM_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    // NOTE: storage is reset so the head entry (and thus m_data) reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= tail_q + AW'(1);
            end
            if (pop) begin
                head_q <= head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/obuf_drain.sv
// Drains a contiguous obuf address range into a valid/ready beat stream.
// Optional OBUF_DRAIN_STALL_CNT_EN adds a saturating stall_cycles counter output.
module obuf_drain
    import obuf_drain_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DEFAULT_MEM_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEFAULT_LEN_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      num_beats,
    output logic                      busy,
    output logic                      done,
    output logic                      obuf_read_req,
    output logic [MEM_ADDR_WIDTH-1:0] obuf_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] obuf_read_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [MEM_DATA_WIDTH-1:0] m_data,
    output logic                      m_last
`ifdef OBUF_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                    state_q;
    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      issued_q;
    logic [LEN_WIDTH-1:0]      accepted_q;
    logic                      inflight_q;
    logic                      done_q;

    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             credit_used;
    logic                      fire;
    logic                      last_issue;

    // A read is only issued when the FIFO can absorb it even if nothing is popped meanwhile.
    assign credit_used    = fifo_count + CW'(inflight_q);
    assign obuf_read_req  = (state_q == ISSUE) && (credit_used < CW'(FIFO_DEPTH));
    assign obuf_read_addr = base_q + MEM_ADDR_WIDTH'(issued_q);
    assign last_issue     = obuf_read_req && (issued_q == len_q - LEN_WIDTH'(1));

    assign m_valid = (fifo_count != '0);
    assign m_last  = m_valid && (accepted_q == len_q - LEN_WIDTH'(1));
    assign fire    = m_valid && m_ready;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    obuf_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MEM_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (obuf_read_data),
        .pop       (fire),
        .count     (fifo_count),
        .head_data (m_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= obuf_read_req;
            done_q     <= 1'b0;
            if (fire) begin
                accepted_q <= accepted_q + LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        len_q      <= num_beats;
                        issued_q   <= '0;
                        accepted_q <= '0;
                        if (num_beats == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (obuf_read_req) begin
                        issued_q <= issued_q + LEN_WIDTH'(1);
                    end
                    if (last_issue) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fire && m_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OBUF_DRAIN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
